// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button conditioning front end: the
// per-channel FSM state encoding, the default timing constants and the
// counter-sizing helpers.
package button_debouncer_pkg;

    // Defaults correspond to a 100 MHz system clock.
    localparam int unsigned DEF_N_CH            = 32'd4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd2000000;   // 20 ms
    localparam int unsigned DEF_HOLD_CYCLES     = 32'd50000000;  // 500 ms
    localparam int unsigned DEF_REPEAT_CYCLES   = 32'd10000000;  // 100 ms

    // One-hot channel state.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ARM     = 5'b00010,
        ST_PRESS   = 5'b00100,
        ST_HELD    = 5'b01000,
        ST_RELEASE = 5'b10000
    } db_state_t;

    // Bits needed to hold any value 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(max_val + 32'd1);
        end
    endfunction

    // The debounced level is high in every state between acceptance and
    // the end of the release qualification.
    function automatic logic is_active(input db_state_t st);
        return (st == ST_PRESS) || (st == ST_HELD) || (st == ST_RELEASE);
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One button channel: two-flop synchroniser, debounce/repeat FSM and its
// counters. All outputs come straight from flops.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic dpb,
    output logic scen,
    output logic mcen,
    output logic ccen
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HW = cnt_width(HOLD_CYCLES);
    localparam int unsigned RW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] PER_MAX  = RW'(REPEAT_CYCLES);

    logic            sync1_r;
    logic            sync2_r;
    db_state_t       state_r;
    db_state_t       state_s;
    logic [DW-1:0]   deb_cnt_r;
    logic [DW-1:0]   deb_cnt_s;
    logic [DW-1:0]   deb_inc_s;
    logic [HW-1:0]   hold_cnt_r;
    logic [HW-1:0]   hold_cnt_s;
    logic [HW-1:0]   hold_step_s;
    logic [RW-1:0]   per_cnt_r;
    logic [RW-1:0]   per_cnt_s;
    logic [RW-1:0]   per_inc_s;
    logic [RW-1:0]   rep_per_s;
    logic            rep_ccen_s;
    logic            rep_mcen_s;
    logic            dpb_r;
    logic            scen_r;
    logic            mcen_r;
    logic            ccen_r;
    logic            dpb_s;
    logic            scen_s;
    logic            mcen_s;
    logic            ccen_s;

    // Debounce counter only ever holds 0..DEBOUNCE_CYCLES-1, so the
    // increment cannot overflow; the same holds for the period counter.
    assign deb_inc_s   = deb_cnt_r + DW'(1'b1);
    assign per_inc_s   = per_cnt_r + RW'(1'b1);
    // Hold counter saturates so MCEN stays enabled for the rest of the hold.
    assign hold_step_s = (hold_cnt_r == HOLD_MAX) ? hold_cnt_r
                                                  : hold_cnt_r + HW'(1'b1);
    // Repeat tick while the button is held: CCEN always, MCEN once saturated.
    assign rep_ccen_s  = (per_inc_s == PER_MAX);
    assign rep_mcen_s  = rep_ccen_s && (hold_step_s == HOLD_MAX);
    assign rep_per_s   = rep_ccen_s ? {RW{1'b0}} : per_inc_s;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, counter and pulse decode for the debounce FSM.
    always_comb begin
        state_s    = state_r;
        deb_cnt_s  = deb_cnt_r;
        hold_cnt_s = hold_cnt_r;
        per_cnt_s  = per_cnt_r;
        scen_s     = 1'b0;
        mcen_s     = 1'b0;
        ccen_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                deb_cnt_s = {DW{1'b0}};
                if (sync2_r) begin
                    state_s = ST_ARM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!sync2_r) begin
                    state_s   = ST_IDLE;
                    deb_cnt_s = {DW{1'b0}};
                end else if (deb_inc_s == DEB_MAX) begin
                    // Accepted press: all three enables fire together and
                    // the repeat timers start from zero.
                    state_s    = ST_PRESS;
                    deb_cnt_s  = {DW{1'b0}};
                    hold_cnt_s = {HW{1'b0}};
                    per_cnt_s  = {RW{1'b0}};
                    scen_s     = 1'b1;
                    mcen_s     = 1'b1;
                    ccen_s     = 1'b1;
                end else begin
                    state_s   = ST_ARM;
                    deb_cnt_s = deb_inc_s;
                end
            end
            ST_PRESS: begin
                // Timers already run during the single PRESS cycle.
                state_s    = ST_HELD;
                hold_cnt_s = hold_step_s;
                per_cnt_s  = rep_per_s;
                ccen_s     = rep_ccen_s;
                mcen_s     = rep_mcen_s;
            end
            ST_HELD: begin
                if (!sync2_r) begin
                    state_s   = ST_RELEASE;
                    deb_cnt_s = {DW{1'b0}};
                end else begin
                    state_s    = ST_HELD;
                    hold_cnt_s = hold_step_s;
                    per_cnt_s  = rep_per_s;
                    ccen_s     = rep_ccen_s;
                    mcen_s     = rep_mcen_s;
                end
            end
            ST_RELEASE: begin
                // A bounce back high restarts the qualification in place;
                // it never counts as a new press.
                if (sync2_r) begin
                    state_s   = ST_RELEASE;
                    deb_cnt_s = {DW{1'b0}};
                end else if (deb_inc_s == DEB_MAX) begin
                    state_s   = ST_IDLE;
                    deb_cnt_s = {DW{1'b0}};
                end else begin
                    state_s   = ST_RELEASE;
                    deb_cnt_s = deb_inc_s;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                deb_cnt_s  = {DW{1'b0}};
                hold_cnt_s = {HW{1'b0}};
                per_cnt_s  = {RW{1'b0}};
            end
        endcase
        dpb_s = is_active(state_s);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            deb_cnt_r  <= {DW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            per_cnt_r  <= {RW{1'b0}};
            dpb_r      <= 1'b0;
            scen_r     <= 1'b0;
            mcen_r     <= 1'b0;
            ccen_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            deb_cnt_r  <= deb_cnt_s;
            hold_cnt_r <= hold_cnt_s;
            per_cnt_r  <= per_cnt_s;
            dpb_r      <= dpb_s;
            scen_r     <= scen_s;
            mcen_r     <= mcen_s;
            ccen_r     <= ccen_s;
        end
    end

    assign dpb  = dpb_r;
    assign scen = scen_r;
    assign mcen = mcen_r;
    assign ccen = ccen_r;

endmodule

// File: rtl/button_debouncer.sv
// Push-button front end: N_CH independent debounce channels producing a
// debounced level plus single, auto-repeat and continuous enable pulses.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned N_CH            = DEF_N_CH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] buttons,
    output logic [N_CH-1:0] DPBs,
    output logic [N_CH-1:0] SCENs,
    output logic [N_CH-1:0] MCENs,
    output logic [N_CH-1:0] CCENs
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .button (buttons[gi]),
            .dpb    (DPBs[gi]),
            .scen   (SCENs[gi]),
            .mcen   (MCENs[gi]),
            .ccen   (CCENs[gi])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with short timing constants. A timestamp-based
// reference model predicts every output each cycle; directed phases follow
// the test plan, then randomized bursts stress the same model.
module tb_button_debouncer;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] buttons = 4'b0000;
    logic [3:0] DPBs;
    logic [3:0] SCENs;
    logic [3:0] MCENs;
    logic [3:0] CCENs;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .N_CH            (4),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .buttons (buttons),
        .DPBs    (DPBs),
        .SCENs   (SCENs),
        .MCENs   (MCENs),
        .CCENs   (CCENs)
    );

    always #5 clk = ~clk;

    // Reference model state: raw-sample delay line plus, per channel, the
    // accepted level, the run of agreeing samples and the acceptance time.
    int   ecount = 0;
    logic d1 [4];
    logic d2 [4];
    int   lvl  [4];
    int   run  [4];
    int   rel  [4];
    int   relr [4];
    int   tacc [4];
    logic [3:0] exp_dpb = 4'b0000;
    logic [3:0] exp_sc  = 4'b0000;
    logic [3:0] exp_mc  = 4'b0000;
    logic [3:0] exp_cc  = 4'b0000;

    task automatic model_edge(input logic [3:0] raw, input logic rst);
        logic x;
        int   k;
        ecount++;
        for (int ch = 0; ch < 4; ch++) begin
            exp_sc[ch] = 1'b0;
            exp_mc[ch] = 1'b0;
            exp_cc[ch] = 1'b0;
            if (rst) begin
                d1[ch] = 1'b0; d2[ch] = 1'b0;
                lvl[ch] = 0; run[ch] = 0; rel[ch] = 0; relr[ch] = 0; tacc[ch] = 0;
            end else begin
                x = d2[ch];
                d2[ch] = d1[ch];
                d1[ch] = raw[ch];
                if (lvl[ch] == 0) begin
                    // Accept after D+1 consecutive high samples while idle.
                    run[ch] = x ? run[ch] + 1 : 0;
                    if (run[ch] == D + 1) begin
                        lvl[ch] = 1; rel[ch] = 0; run[ch] = 0; tacc[ch] = ecount;
                        exp_sc[ch] = 1'b1; exp_mc[ch] = 1'b1; exp_cc[ch] = 1'b1;
                    end
                end else if (rel[ch] == 0) begin
                    k = ecount - tacc[ch];
                    if (k > 1 && x == 1'b0) begin
                        rel[ch] = 1; relr[ch] = 0;
                    end else if (k % R == 0) begin
                        exp_cc[ch] = 1'b1;
                        if (k >= H) exp_mc[ch] = 1'b1;
                    end
                end else begin
                    if (x) begin
                        relr[ch] = 0;
                    end else begin
                        relr[ch]++;
                        if (relr[ch] == D) begin
                            lvl[ch] = 0; rel[ch] = 0; run[ch] = 0;
                        end
                    end
                end
            end
            exp_dpb[ch] = (lvl[ch] != 0);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic chk_outputs();
        chk("dpb",  int'(DPBs),  int'(exp_dpb));
        chk("scen", int'(SCENs), int'(exp_sc));
        chk("mcen", int'(MCENs), int'(exp_mc));
        chk("ccen", int'(CCENs), int'(exp_cc));
    endtask

    // Drive one raw vector, clock it, update the model, then compare.
    task automatic step(input logic [3:0] v);
        buttons = v;
        @(posedge clk);
        model_edge(v, reset);
        #1;
        chk_outputs();
    endtask

    initial begin
        int first_sc, first_mrep, n_sc, n_mc, n_cc, fall, late;
        int len;
        logic [3:0] v;

        // Reset state.
        reset = 1'b1;
        repeat (3) step(4'b0000);
        reset = 1'b0;
        repeat (4) step(4'b0000);

        // Clean press on channel 0, held 30 cycles (local edge 0 = first high).
        first_sc = -1; first_mrep = -1; n_sc = 0; n_mc = 0; n_cc = 0;
        for (int i = 0; i < 30; i++) begin
            step(4'b0001);
            if (SCENs[0]) begin n_sc++; if (first_sc < 0) first_sc = i; end
            if (MCENs[0]) begin n_mc++; if (first_sc >= 0 && i > first_sc && first_mrep < 0) first_mrep = i; end
            if (CCENs[0]) n_cc++;
        end
        chk("press_first_scen_edge", first_sc, 6);
        chk("press_first_mcen_repeat_edge", first_mrep, 18);
        chk("press_scen_count", n_sc, 1);
        chk("press_ccen_count", n_cc, 8);
        chk("press_mcen_count", n_mc, 5);

        // Release debounce on channel 0.
        fall = -1; late = 0;
        for (int j = 0; j < 12; j++) begin
            step(4'b0000);
            if (!DPBs[0] && fall < 0) fall = j;
            if (j >= 2 && (SCENs[0] || MCENs[0] || CCENs[0])) late++;
        end
        chk("release_dpb_fall_edge", fall, 6);
        chk("release_late_pulses", late, 0);

        // Bounce on channel 1 followed by a steady 5-cycle high.
        n_sc = 0;
        begin
            logic [6:0] pat;
            pat = 7'b0111011;   // applied LSB first: 1,1,0,1,1,1,0
            for (int i = 0; i < 7; i++) begin
                step({2'b00, pat[i], 1'b0});
                if (SCENs[1] || DPBs[1]) n_sc++;
            end
        end
        chk("bounce_no_output", n_sc, 0);
        for (int i = 0; i < 5; i++) begin step(4'b0010); if (SCENs[1]) n_sc++; end
        for (int i = 0; i < 14; i++) begin step(4'b0000); if (SCENs[1]) n_sc++; end
        chk("bounce_then_steady_scen_count", n_sc, 1);

        // Release glitch on channel 2: the 2-cycle high delays DPB, no re-press.
        n_sc = 0;
        for (int i = 0; i < 8; i++) begin step(4'b0100); if (SCENs[2]) n_sc++; end
        step(4'b0000); step(4'b0000);
        step(4'b0100); step(4'b0100);
        for (int i = 0; i < 16; i++) begin step(4'b0000); if (SCENs[2]) n_sc++; end
        chk("glitch_scen_count", n_sc, 1);

        // Simultaneous press on all channels.
        first_sc = -1;
        for (int i = 0; i < 20; i++) begin
            step(4'b1111);
            if (SCENs == 4'b1111 && first_sc < 0) first_sc = i;
        end
        chk("simultaneous_scen_edge", first_sc, 6);

        // Reset in the middle of the hold.
        reset = 1'b1;
        step(4'b1111);
        chk("reset_mid_hold_outputs", int'({DPBs, SCENs, MCENs, CCENs}), 0);
        reset = 1'b0;
        first_sc = -1;
        for (int i = 0; i < 10; i++) begin
            step(4'b1111);
            if (SCENs == 4'b1111 && first_sc < 0) first_sc = i;
        end
        chk("post_reset_scen_edge", first_sc, 6);
        repeat (14) step(4'b0000);

        // Short press on channel 3: one of each pulse, no repeats.
        n_sc = 0; n_mc = 0; n_cc = 0;
        for (int i = 0; i < 5; i++) begin
            step(4'b1000);
            if (SCENs[3]) n_sc++; if (MCENs[3]) n_mc++; if (CCENs[3]) n_cc++;
        end
        for (int i = 0; i < 16; i++) begin
            step(4'b0000);
            if (SCENs[3]) n_sc++; if (MCENs[3]) n_mc++; if (CCENs[3]) n_cc++;
        end
        chk("short_press_scen", n_sc, 1);
        chk("short_press_mcen", n_mc, 1);
        chk("short_press_ccen", n_cc, 1);

        // Randomized bursts, with one reset dropped in midway.
        for (int b = 0; b < 60; b++) begin
            v   = 4'($urandom_range(0, 15));
            len = int'($urandom_range(1, 14));
            if (b == 30) reset = 1'b1;
            for (int i = 0; i < len; i++) begin
                step(v);
                reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
